// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
//   sub_state_t       : FSM state encoding (IDLE, SHIFT, DONE)
//   SUB_WIDTH_DEFAULT : default operand/result width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: one-bit full subtractor, purely combinational.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit  (a - b - bin)
//   bout : borrow out
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first WIDTH-bit subtractor (diff = a - b),
// one bit per clock through a single full_subtractor_cell and one borrow FF.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : request a subtraction (sampled only in IDLE)
//   a, b       : unsigned operands, captured on an accepted start
//   busy       : high in SHIFT and DONE
//   done       : one-cycle pulse, result valid
//   diff       : a - b modulo 2^WIDTH, held until the next completed operation
//   borrow_out : 1 iff a < b unsigned
//   overflow   : signed overflow; exists only when SERIAL_SUB_OVERFLOW_EN is defined
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    // Holds the WIDTH-1 bits already produced; the final bit is merged
    // straight into diff on the last SHIFT cycle.
    logic [WIDTH-2:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             br_next;

    full_subtractor_cell u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (d),
        .bout (br_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // Zero-fill right shift: on the last cycle sa[0]/sb[0]
                    // are exactly the operand MSBs captured at start.
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_next;
                    cnt <= cnt + 1'b1;
                    res <= (WIDTH-1)'({d, res} >> 1);
                    if (cnt == CNT_LAST) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        diff       <= {d, res};
                        borrow_out <= br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        overflow   <= (sa[0] ^ sb[0]) & (sa[0] ^ d);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
